// File: rtl/fp_pkg.sv
// fp_pkg -- shared binary32 definitions for the floating-point datapath.
//
// Holds the field widths, the special encodings, the fp32_t field view and
// the pack/unpack helpers. The adder and the multiplier both import it.
package fp_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS  = 127;

    // All-ones exponent: marks Inf/NaN, and is the overflow threshold.
    localparam logic [EXP_W-1:0] EXP_MAX = EXP_W'(2 * BIAS + 1);

    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam logic [31:0] POS_INF = 32'h7F800000;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp32_t;

    function automatic fp32_t fp_unpack(input logic [31:0] word);
        return fp32_t'(word);
    endfunction

    function automatic logic [31:0] fp_pack(input fp32_t value);
        return value;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// fp_lzc -- leading-zero counter for the 27-bit normalisation path.
//
// Ports:
//   value  in  27  magnitude to be normalised (bit 26 is the MSB)
//   count  out  5  number of leading zeros; 27 when value is zero
module fp_lzc (
    input  logic [26:0] value,
    output logic [4:0]  count
);

    // Scan upward so the highest set bit is the last one to write count.
    always_comb begin
        count = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (value[i]) begin
                count = 5'(26 - i);
            end
        end
    end

endmodule

// File: rtl/fp_add.sv
// fp_add -- IEEE-754 binary32 adder/subtractor.
//
// Round-to-nearest-even, subnormal inputs and results flushed to signed zero,
// canonical qNaN for every invalid case. PIPELINED=1 registers after each of
// the four stages (latency 4); PIPELINED=0 keeps only the output register
// (latency 1). The stage logic is shared, so both builds are bit-identical.
//
// Ports:
//   clk      in   1  rising-edge clock
//   rst_n    in   1  asynchronous active-low reset, clears every register
//   ADD_SUB  in   1  1: FP_A + FP_B, 0: FP_A - FP_B
//   FP_A     in  32  operand A
//   FP_B     in  32  operand B
//   FP_Z     out 32  registered result
module fp_add
    import fp_pkg::*;
#(
    parameter int PIPELINED = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ADD_SUB,
    input  logic [31:0] FP_A,
    input  logic [31:0] FP_B,
    output logic [31:0] FP_Z
);

    // Special results (NaN, Inf, zero operands) are resolved up front and
    // ride the pipeline alongside the arithmetic path, overriding it in S4.
    typedef struct packed {
        logic             special;
        logic [31:0]      special_val;
        logic             sign;
        logic             eff_sub;
        logic [EXP_W-1:0] exp_l;
        logic [MAN_W:0]   man_l;
        logic [MAN_W:0]   man_s;
        logic [EXP_W-1:0] exp_diff;
    } s1_t;

    typedef struct packed {
        logic             special;
        logic [31:0]      special_val;
        logic             sign;
        logic [EXP_W-1:0] exp_l;
        logic [27:0]      sum;      // carry-out + 24-bit mantissa + G/R/S
    } s2_t;

    typedef struct packed {
        logic             special;
        logic [31:0]      special_val;
        logic             sign;
        logic             zero;
        logic [9:0]       exp;      // two's complement, may go below 1
        logic [26:0]      norm;     // hidden bit at 26, G/R/S at 2:0
    } s3_t;

    s1_t s1_d, s1_q;
    s2_t s2_d, s2_q;
    s3_t s3_d, s3_q;

    // ---------------- S1: unpack, specials, compare/swap ----------------
    fp32_t op_a, op_b;
    logic  nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, a_ge_b;

    always_comb begin
        op_a      = fp_unpack(FP_A);
        op_b      = fp_unpack(FP_B);
        op_b.sign = FP_B[31] ^ ~ADD_SUB;

        nan_a  = (op_a.exp == EXP_MAX) && (op_a.man != '0);
        nan_b  = (op_b.exp == EXP_MAX) && (op_b.man != '0);
        inf_a  = (op_a.exp == EXP_MAX) && (op_a.man == '0);
        inf_b  = (op_b.exp == EXP_MAX) && (op_b.man == '0);
        zero_a = (op_a.exp == '0);
        zero_b = (op_b.exp == '0);
        a_ge_b = {op_a.exp, op_a.man} >= {op_b.exp, op_b.man};

        s1_d         = '0;
        s1_d.eff_sub = op_a.sign ^ op_b.sign;
        if (a_ge_b) begin
            s1_d.sign     = op_a.sign;
            s1_d.exp_l    = op_a.exp;
            s1_d.man_l    = {1'b1, op_a.man};
            s1_d.man_s    = {1'b1, op_b.man};
            s1_d.exp_diff = op_a.exp - op_b.exp;
        end else begin
            s1_d.sign     = op_b.sign;
            s1_d.exp_l    = op_b.exp;
            s1_d.man_l    = {1'b1, op_b.man};
            s1_d.man_s    = {1'b1, op_a.man};
            s1_d.exp_diff = op_b.exp - op_a.exp;
        end

        s1_d.special = 1'b1;
        if (nan_a || nan_b || (inf_a && inf_b && (op_a.sign != op_b.sign))) begin
            s1_d.special_val = QNAN;
        end else if (inf_a) begin
            s1_d.special_val = {op_a.sign, POS_INF[30:0]};
        end else if (inf_b) begin
            s1_d.special_val = {op_b.sign, POS_INF[30:0]};
        end else if (zero_a && zero_b) begin
            s1_d.special_val = {op_a.sign & op_b.sign, 31'b0};
        end else if (zero_a) begin
            s1_d.special_val = fp_pack(op_b);
        end else if (zero_b) begin
            s1_d.special_val = fp_pack(op_a);
        end else begin
            s1_d.special = 1'b0;
        end
    end

    // ---------------- S2: align and add/subtract ----------------
    logic [26:0] ext_s, shifted, lost, aligned;
    logic [27:0] mag_l;

    always_comb begin
        ext_s   = {s1_q.man_s, 3'b000};
        shifted = ext_s >> s1_q.exp_diff;
        lost    = ext_s & ~({27{1'b1}} << s1_q.exp_diff);
        // At 26 or more the hidden bit lands in or past the sticky position,
        // so the whole operand reduces to a single sticky bit.
        if (s1_q.exp_diff >= 8'd26) begin
            aligned = 27'd1;
        end else begin
            aligned = {shifted[26:1], shifted[0] | (|lost)};
        end
        mag_l = {1'b0, s1_q.man_l, 3'b000};

        s2_d.special     = s1_q.special;
        s2_d.special_val = s1_q.special_val;
        s2_d.sign        = s1_q.sign;
        s2_d.exp_l       = s1_q.exp_l;
        s2_d.sum         = s1_q.eff_sub ? (mag_l - {1'b0, aligned})
                                        : (mag_l + {1'b0, aligned});
    end

    // ---------------- S3: leading-zero count and normalise ----------------
    logic [4:0] lz;

    fp_lzc u_lzc (
        .value (s2_q.sum[26:0]),
        .count (lz)
    );

    always_comb begin
        s3_d.special     = s2_q.special;
        s3_d.special_val = s2_q.special_val;
        s3_d.sign        = s2_q.sign;
        s3_d.zero        = (s2_q.sum == '0);
        if (s2_q.sum[27]) begin
            // Carry out: shift right one, folding the dropped bit into sticky.
            s3_d.norm = {s2_q.sum[27:2], s2_q.sum[1] | s2_q.sum[0]};
            s3_d.exp  = {2'b00, s2_q.exp_l} + 10'd1;
        end else begin
            s3_d.norm = s2_q.sum[26:0] << lz;
            s3_d.exp  = {2'b00, s2_q.exp_l} - {5'b00000, lz};
        end
    end

    // ---------------- S4: round, range check, pack ----------------
    logic        round_up;
    logic [24:0] man_r;
    logic [9:0]  exp_r;
    fp32_t       packed_res;
    logic [31:0] z_d;

    always_comb begin
        round_up = s3_q.norm[2] & (s3_q.norm[1] | s3_q.norm[0] | s3_q.norm[3]);
        man_r    = {1'b0, s3_q.norm[26:3]} + {24'b0, round_up};
        exp_r    = s3_q.exp + {9'b0, man_r[24]};

        packed_res.sign = s3_q.sign;
        packed_res.exp  = exp_r[7:0];
        packed_res.man  = man_r[24] ? man_r[23:1] : man_r[22:0];

        if (s3_q.special) begin
            z_d = s3_q.special_val;
        end else if (s3_q.zero) begin
            z_d = 32'h00000000;                       // exact cancellation
        end else if (exp_r[9] || (exp_r == 10'd0)) begin
            z_d = {s3_q.sign, 31'b0};                 // below min normal
        end else if (exp_r >= 10'd255) begin
            z_d = {s3_q.sign, POS_INF[30:0]};
        end else begin
            z_d = fp_pack(packed_res);
        end
    end

    // ---------------- stage registers ----------------
    generate
        if (PIPELINED != 0) begin : g_pipe
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_q <= '0;
                    s2_q <= '0;
                    s3_q <= '0;
                end else begin
                    s1_q <= s1_d;
                    s2_q <= s2_d;
                    s3_q <= s3_d;
                end
            end
        end else begin : g_comb
            assign s1_q = s1_d;
            assign s2_q = s2_d;
            assign s3_q = s3_d;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            FP_Z <= '0;
        end else begin
            FP_Z <= z_d;
        end
    end

endmodule

// File: tb/tb_fp_add.sv
// tb_fp_add -- self-checking bench for fp_add.
//
// Runs a pipelined and a single-cycle instance side by side on the same
// operand stream. Directed vectors carry hand-derived expected values;
// random vectors are checked against an exact big-integer reference that
// rounds the true sum to nearest-even.
module tb_fp_add;
    import fp_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        add_sub = 1'b1;
    logic [31:0] fp_a = '0;
    logic [31:0] fp_b = '0;
    logic [31:0] z_pipe, z_comb;

    int          n_assert = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    fp_add #(.PIPELINED(1)) dut_pipe (
        .clk(clk), .rst_n(rst_n), .ADD_SUB(add_sub),
        .FP_A(fp_a), .FP_B(fp_b), .FP_Z(z_pipe)
    );

    fp_add #(.PIPELINED(0)) dut_comb (
        .clk(clk), .rst_n(rst_n), .ADD_SUB(add_sub),
        .FP_A(fp_a), .FP_B(fp_b), .FP_Z(z_comb)
    );

    // Exact reference: scale both operands to integers in units of 2^-149,
    // form the exact sum, then round to 24 significant bits.
    function automatic logic [31:0] ref_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic as);
        logic         sa, sb, s;
        logic [7:0]   ea, eb;
        logic [22:0]  ma, mb;
        logic [279:0] va, vb, sum, top, rem, half;
        logic [24:0]  m;
        int           p, e;
        sa = a[31]; ea = a[30:23]; ma = a[22:0];
        sb = b[31] ^ ~as; eb = b[30:23]; mb = b[22:0];
        if ((ea == 8'hFF && ma != 0) || (eb == 8'hFF && mb != 0)) return QNAN;
        if (ea == 8'hFF && eb == 8'hFF) return (sa != sb) ? QNAN : {sa, 8'hFF, 23'h0};
        if (ea == 8'hFF) return {sa, 8'hFF, 23'h0};
        if (eb == 8'hFF) return {sb, 8'hFF, 23'h0};
        if (ea == 0 && eb == 0) return {sa & sb, 31'h0};
        if (ea == 0) return {sb, b[30:0]};
        if (eb == 0) return a;
        va = {256'b0, 1'b1, ma} << (ea - 8'd1);
        vb = {256'b0, 1'b1, mb} << (eb - 8'd1);
        if (sa == sb) begin
            sum = va + vb; s = sa;
        end else if (va >= vb) begin
            sum = va - vb; s = sa;
        end else begin
            sum = vb - va; s = sb;
        end
        if (sum == 0) return 32'h0;
        p = 0;
        for (int i = 0; i < 280; i++) if (sum[i]) p = i;
        if (p < 23) return {s, 31'h0};
        top = sum >> (p - 23);
        m   = {1'b0, top[23:0]};
        if (p > 23) begin
            rem  = sum - (top << (p - 23));
            half = 280'(1) << (p - 24);
            if (rem > half || (rem == half && m[0])) m = m + 25'd1;
        end
        e = p - 22;
        if (m[24]) begin
            m = m >> 1;
            e = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'h0};
        return {s, 8'(e), m[22:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_assert++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, got, want);
        end
    endtask

    // Drive one operand pair and check both outputs one edge later.
    task automatic do_op(input string tag, input logic as, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] want);
        logic [31:0] want_pipe;
        add_sub = as; fp_a = a; fp_b = b;
        exp_q.push_back(want);
        @(posedge clk);
        #1;
        want_pipe = exp_q.pop_front();
        $display("%-10s as=%0d a=%08h b=%08h comb=%08h pipe=%08h", tag, as, a, b, z_comb, z_pipe);
        check({tag, " comb"}, z_comb, want);
        check({tag, " pipe"}, z_pipe, want_pipe);
    endtask

    task automatic prime_queue();
        exp_q.delete();
        for (int i = 0; i < 3; i++) exp_q.push_back(32'h0);
    endtask

    task automatic rand_op(input string tag);
        logic [31:0] a, b;
        logic [7:0]  ea;
        logic        as;
        a  = $urandom;
        ea = a[30:23];
        as = 1'($urandom);
        case ($urandom_range(0, 4))
            0: b = $urandom;
            1: b = {1'($urandom), 8'(32'(ea) + $urandom_range(0, 6) - 3), 23'($urandom)};
            2: b = {1'($urandom), ea, 23'($urandom)};
            3: b = {1'($urandom), ea - 8'($urandom_range(22, 28)), 23'($urandom)};
            default: b = {1'($urandom), ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00,
                          ($urandom_range(0, 1) != 0) ? 23'h0 : 23'($urandom)};
        endcase
        do_op(tag, as, a, b, ref_add(a, b, as));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Asynchronous reset at start, observed before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        check("reset comb", z_comb, 32'h0);
        check("reset pipe", z_pipe, 32'h0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        prime_queue();

        // Directed vectors, issued back to back.
        do_op("t2e_add",  1'b1, 32'h12345678, 32'h9ABCDEF1, 32'h9ABCDE97);
        do_op("t2e_sub",  1'b0, 32'h12345678, 32'h9ABCDEF1, 32'h1ABCDF4B);
        do_op("one_one",  1'b1, 32'h3F800000, 32'h3F800000, 32'h40000000);
        do_op("1p5_2p25", 1'b1, 32'h3FC00000, 32'h40100000, 32'h40700000);
        do_op("one_m_one",1'b0, 32'h3F800000, 32'h3F800000, 32'h00000000);
        do_op("inf_ninf", 1'b1, 32'h7F800000, 32'hFF800000, 32'h7FC00000);
        do_op("nan_one",  1'b1, 32'h7F800001, 32'h3F800000, 32'h7FC00000);
        do_op("max_max",  1'b1, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000);
        do_op("nz_nz",    1'b1, 32'h80000000, 32'h80000000, 32'h80000000);
        do_op("sub_sub",  1'b1, 32'h00000001, 32'h00000001, 32'h00000000);
        do_op("inf_one",  1'b1, 32'h7F800000, 32'h3F800000, 32'h7F800000);
        do_op("zero_m1",  1'b0, 32'h00000000, 32'h3F800000, 32'hBF800000);
        do_op("far_sticky",1'b1,32'h3F800000, 32'h30800000, 32'h3F800000);
        do_op("tie_even", 1'b1, 32'h3F800000, 32'h33800000, 32'h3F800000);
        do_op("above_tie",1'b1, 32'h3F800000, 32'h33800001, 32'h3F800001);
        do_op("neg_neg",  1'b1, 32'hBF800000, 32'hBF800000, 32'hC0000000);
        do_op("uflow_neg",1'b0, 32'h00800000, 32'h00800001, 32'h80000000);

        // Constant operands held for 12 cycles: both builds must agree.
        for (int i = 0; i < 12; i++) do_op("hold", 1'b1, 32'h12345678, 32'h9ABCDEF1, 32'h9ABCDE97);
        check("hold match", z_pipe, z_comb);

        for (int i = 0; i < 160; i++) rand_op($sformatf("rand%0d", i));

        // Reset mid-stream: in-flight results must be discarded.
        #3 rst_n = 1'b0;
        #1;
        check("midrst comb", z_comb, 32'h0);
        check("midrst pipe", z_pipe, 32'h0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        prime_queue();
        for (int i = 0; i < 20; i++) rand_op($sformatf("post%0d", i));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
